// File: rtl/uart_rx_if.sv
// Receive-side bundle between the UART receiver and its host logic.
// slave = receiver side, master = host/pad side driving tick, line and ready.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud_tick;
    logic                 rx;
    logic                 parity_en;
    logic                 parity_odd;
    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport slave (
        input  baud_tick, rx, parity_en, parity_odd, rx_ready,
        output rx_data, rx_valid, parity_err, frame_err, overrun, busy
    );

    modport master (
        output baud_tick, rx, parity_en, parity_odd, rx_ready,
        input  rx_data, rx_valid, parity_err, frame_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversampled framing of start/data/parity/stop into a
// valid/ready holding register with parity, frame and overrun flags.
// Ports: clk, arst_n (sync, active-low), bus (uart_rx_if.slave).
// Optional: define UART_RX_MAJORITY_VOTE_EN for 3-sample majority voting.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic     clk,
    input  logic     arst_n,
    uart_rx_if.slave bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] C_SAMP = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] C_V0   = CW'(OVERSAMPLE / 2 - 2);
    localparam logic [CW-1:0] C_V1   = CW'(OVERSAMPLE / 2 - 1);
`else
    localparam logic [CW-1:0] C_SAMP = CW'(OVERSAMPLE / 2 - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t               r_state, w_state_nx;
    logic [CW-1:0]        r_cnt, w_cnt_nx;
    logic [IW-1:0]        r_idx, w_idx_nx;
    logic [DATA_BITS-1:0] r_shift, w_shift_nx;
    logic                 r_pmis, w_pmis_nx;
    logic                 r_sync1, r_rx_s;
    logic                 w_bit, w_samp, w_commit;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_perr, r_ferr, r_ovr;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic r_v0, r_v1;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_v0 <= 1'b1;
            r_v1 <= 1'b1;
        end else if (bus.baud_tick) begin
            if (r_cnt == C_V0) r_v0 <= r_rx_s;
            if (r_cnt == C_V1) r_v1 <= r_rx_s;
        end
    end

    assign w_bit = (r_v0 & r_v1) | (r_v0 & r_rx_s) | (r_v1 & r_rx_s);
`else
    assign w_bit = r_rx_s;
`endif

    assign w_samp = (r_cnt == C_SAMP);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_pmis_nx  = r_pmis;
        w_commit   = 1'b0;
        if (bus.baud_tick) begin
            w_cnt_nx = (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    w_cnt_nx = '0;
                    // detection tick is cnt 0, so the next tick is cnt 1
                    if (!r_rx_s) begin
                        w_state_nx = S_START;
                        w_cnt_nx   = CW'(1);
                        w_idx_nx   = '0;
                        w_pmis_nx  = 1'b0;
                    end
                end
                S_START: begin
                    if (w_samp && w_bit) begin
                        w_state_nx = S_IDLE;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == C_LAST) begin
                        w_state_nx = S_DATA;
                        w_idx_nx   = '0;
                    end
                end
                S_DATA: begin
                    if (w_samp)
                        w_shift_nx = {w_bit, r_shift[DATA_BITS-1:1]};
                    if (r_cnt == C_LAST) begin
                        if (r_idx == I_LAST)
                            w_state_nx = bus.parity_en ? S_PARITY : S_STOP;
                        else
                            w_idx_nx = r_idx + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_samp)
                        w_pmis_nx = w_bit != (^r_shift ^ bus.parity_odd);
                    if (r_cnt == C_LAST)
                        w_state_nx = S_STOP;
                end
                S_STOP: begin
                    // frame ends mid-stop for half a bit of resync margin
                    if (w_samp) begin
                        w_commit   = 1'b1;
                        w_cnt_nx   = '0;
                        w_state_nx = w_bit ? S_IDLE : S_BREAK;
                    end
                end
                S_BREAK: begin
                    w_cnt_nx = '0;
                    if (r_rx_s) w_state_nx = S_IDLE;
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_pmis  <= 1'b0;
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_shift <= w_shift_nx;
            r_pmis  <= w_pmis_nx;
            r_sync1 <= bus.rx;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (w_commit) begin
            if (!r_valid || bus.rx_ready) begin
                r_data  <= r_shift;
                r_perr  <= r_pmis;
                r_ferr  <= !w_bit;
                r_valid <= 1'b1;
                // old word consumed in this same cycle
                if (r_valid) r_ovr <= 1'b0;
            end else begin
                r_ovr <= 1'b1;
            end
        end else if (r_valid && bus.rx_ready) begin
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end
    end

    assign bus.rx_data    = r_data;
    assign bus.rx_valid   = r_valid;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;
    assign bus.overrun    = r_ovr;
    assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed bench for uart_rx against a frame-level model.
// Ticks every 4 clk, 16 ticks per bit; inputs change on negedge.
module tb_uart_rx;
    localparam int DB = 8;
    localparam int OS = 16;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS)
    ) dut (
        .clk   (clk),
        .arst_n(arst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        bus.baud_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            bus.baud_tick = 1'b1;
            @(negedge clk);
            bus.baud_tick = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n * 4) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.rx = b;
        ticks(OS);
    endtask

    // Whole frame at line level; the DUT lags by sync + tick alignment.
    task automatic send_frame(input logic [8:0] d, input logic pbit,
                              input logic stop, input bit chk_lat);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        if (bus.parity_en) send_bit(pbit);
        bus.rx = stop;
        ticks(4);
        if (chk_lat) chk("lat_early", 32'(bus.rx_valid), 0);
        ticks(OS - 4);
    endtask

    task automatic pulse_ready();
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    function automatic logic model_perr(input logic [7:0] d, input logic pen,
                                        input logic podd, input logic pbit);
        int ones;
        ones = $countones({pbit, d});
        if (!pen) return 1'b0;
        // even parity: total ones even; odd parity: total ones odd
        return podd ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    initial begin
        logic [7:0] d;
        logic       pen, podd, pbit;

        bus.rx = 1'b1;
        bus.parity_en = 1'b0;
        bus.parity_odd = 1'b0;
        bus.rx_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_valid", 32'(bus.rx_valid), 0);
        chk("rst_data", 32'(bus.rx_data), 0);
        chk("rst_flags", {bus.parity_err, bus.frame_err, bus.overrun}, 0);
        chk("rst_busy", 32'(bus.busy), 0);
        arst_n = 1'b1;
        ticks(4);

        send_frame(9'h0A5, 1'b0, 1'b1, 1'b1);
        chk("a5_valid", 32'(bus.rx_valid), 1);
        chk("a5_data", 32'(bus.rx_data), 32'hA5);
        chk("a5_ferr", 32'(bus.frame_err), 0);
        chk("a5_perr", 32'(bus.parity_err), 0);
        repeat (5) @(negedge clk);
        chk("a5_hold", 32'(bus.rx_valid), 1);
        pulse_ready();
        chk("a5_clr", 32'(bus.rx_valid), 0);
        chk("a5_keep", 32'(bus.rx_data), 32'hA5);

        bus.parity_en = 1'b1;
        bus.parity_odd = 1'b0;
        send_frame(9'h03C, 1'b0, 1'b1, 1'b0);
        chk("p0_valid", 32'(bus.rx_valid), 1);
        chk("p0_perr", 32'(bus.parity_err), 0);
        pulse_ready();
        send_frame(9'h03C, 1'b1, 1'b1, 1'b0);
        chk("p1_perr", 32'(bus.parity_err), 1);
        chk("p1_data", 32'(bus.rx_data), 32'h3C);
        pulse_ready();
        bus.parity_en = 1'b0;

        bus.rx = 1'b0;
        ticks(2);
        chk("gl_busy", 32'(bus.busy), 1);
        ticks(2);
        bus.rx = 1'b1;
        ticks(12);
        chk("gl_idle", 32'(bus.busy), 0);
        chk("gl_valid", 32'(bus.rx_valid), 0);

        send_frame(9'h055, 1'b0, 1'b0, 1'b0);
        ticks(40);
        chk("br_valid", 32'(bus.rx_valid), 1);
        chk("br_data", 32'(bus.rx_data), 32'h55);
        chk("br_ferr", 32'(bus.frame_err), 1);
        chk("br_busy", 32'(bus.busy), 1);
        pulse_ready();
        ticks(32);
        chk("br_none", 32'(bus.rx_valid), 0);
        chk("br_wait", 32'(bus.busy), 1);
        bus.rx = 1'b1;
        ticks(4);
        chk("br_exit", 32'(bus.busy), 0);
        ticks(8);

        send_frame(9'h011, 1'b0, 1'b1, 1'b0);
        send_frame(9'h022, 1'b0, 1'b1, 1'b0);
        chk("ov_data", 32'(bus.rx_data), 32'h11);
        chk("ov_flag", 32'(bus.overrun), 1);
        chk("ov_ferr", 32'(bus.frame_err), 0);
        pulse_ready();
        chk("ov_valid", 32'(bus.rx_valid), 0);
        chk("ov_clr", 32'(bus.overrun), 0);

        send_frame(9'h081, 1'b0, 1'b1, 1'b0);
        chk("mr_pend", 32'(bus.rx_valid), 1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        bus.rx = 1'b0;
        ticks(8);
        chk("mr_busy", 32'(bus.busy), 1);
        arst_n = 1'b0;
        bus.rx = 1'b1;
        @(negedge clk);
        chk("mr_valid", 32'(bus.rx_valid), 0);
        chk("mr_data", 32'(bus.rx_data), 0);
        chk("mr_busy0", 32'(bus.busy), 0);
        chk("mr_flags", {bus.parity_err, bus.frame_err, bus.overrun}, 0);
        arst_n = 1'b1;
        ticks(20);
        send_frame(9'h0F0, 1'b0, 1'b1, 1'b1);
        chk("f0_valid", 32'(bus.rx_valid), 1);
        chk("f0_data", 32'(bus.rx_data), 32'hF0);
        chk("f0_ferr", 32'(bus.frame_err), 0);
        pulse_ready();

        for (int k = 0; k < 12; k++) begin
            d = 8'($urandom_range(0, 255));
            pen = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            pbit = 1'($urandom_range(0, 1));
            bus.parity_en = pen;
            bus.parity_odd = podd;
            send_frame({1'b0, d}, pbit, 1'b1, 1'b1);
            chk("rnd_valid", 32'(bus.rx_valid), 1);
            chk("rnd_data", 32'(bus.rx_data), 32'(d));
            chk("rnd_perr", 32'(bus.parity_err),
                32'(model_perr(d, pen, podd, pbit)));
            chk("rnd_ferr", 32'(bus.frame_err), 0);
            chk("rnd_ovr", 32'(bus.overrun), 0);
            pulse_ready();
            chk("rnd_clr", 32'(bus.rx_valid), 0);
            ticks($urandom_range(0, 20));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
